// File: rtl/tt_sweep_pkg.sv
// rtl/tt_sweep_pkg.sv - shared types and constants for the truth-table sweep controller
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int DEF_N_IN          = 4;
    localparam int DEF_SETTLE_CYCLES = 2;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_sweep_ctrl_if.sv
// rtl/tt_sweep_ctrl_if.sv - harness/gate bundle for tt_sweep_ctrl; fail_valid/fail_idx exist with TT_SWEEP_FAIL_IDX_EN
interface tt_sweep_ctrl_if #(
    parameter int N_IN = 4
);
    localparam int TT_W = tt_sweep_pkg::tt_width(N_IN);

    logic            start;
    logic            abort;
    logic [TT_W-1:0] expected_tt;
    logic [N_IN-1:0] dut_in;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [TT_W-1:0] signature;
`ifdef TT_SWEEP_FAIL_IDX_EN
    logic            fail_valid;
    logic [N_IN-1:0] fail_idx;
`endif

    modport slave (
        input  start, abort, expected_tt, dut_out,
        output dut_in, busy, done, pass, signature
`ifdef TT_SWEEP_FAIL_IDX_EN
        , output fail_valid, fail_idx
`endif
    );

    modport master (
        output start, abort, expected_tt, dut_out,
        input  dut_in, busy, done, pass, signature
`ifdef TT_SWEEP_FAIL_IDX_EN
        , input fail_valid, fail_idx
`endif
    );

endinterface

// File: rtl/tt_settle_cnt.sv
// rtl/tt_settle_cnt.sv - per-vector settle down-counter with one-cycle expiry strobe
module tt_settle_cnt #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(SETTLE_CYCLES);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Strobe is high for the cycle whose closing edge samples the gate output
    assign expired = en && (cnt == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// rtl/tt_sweep_ctrl.sv - exhaustive truth-table sweep of one gate; TT_SWEEP_FAIL_IDX_EN adds first-mismatch index
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int N_IN          = DEF_N_IN,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    tt_sweep_ctrl_if.slave    bus
);
    localparam int TT_W = tt_width(N_IN);

    state_t          state;
    logic [N_IN-1:0] idx;
    logic [TT_W-1:0] exp_q;
    logic            accept;
    logic            sample;
    logic            run_en;
    logic            cnt_load;

    assign accept   = (state == IDLE) && bus.start && !bus.abort;
    assign run_en   = (state == RUN);
    assign cnt_load = accept || sample;

    tt_settle_cnt #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (cnt_load),
        .en      (run_en),
        .expired (sample)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            exp_q          <= '0;
            bus.dut_in     <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.pass       <= 1'b0;
            bus.signature  <= '0;
`ifdef TT_SWEEP_FAIL_IDX_EN
            bus.fail_valid <= 1'b0;
            bus.fail_idx   <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
            if ((state != IDLE) && bus.abort) begin
                // Partial signature is deliberately kept for post-mortem
                state          <= IDLE;
                bus.busy       <= 1'b0;
                bus.dut_in     <= '0;
                bus.pass       <= 1'b0;
`ifdef TT_SWEEP_FAIL_IDX_EN
                bus.fail_valid <= 1'b0;
                bus.fail_idx   <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            state          <= RUN;
                            idx            <= '0;
                            bus.dut_in     <= '0;
                            bus.signature  <= '0;
                            bus.pass       <= 1'b0;
                            bus.busy       <= 1'b1;
                            exp_q          <= bus.expected_tt;
`ifdef TT_SWEEP_FAIL_IDX_EN
                            bus.fail_valid <= 1'b0;
                            bus.fail_idx   <= '0;
`endif
                        end
                    end
                    RUN: begin
                        if (sample) begin
                            bus.signature[idx] <= bus.dut_out;
                            idx                <= idx + 1'b1;
`ifdef TT_SWEEP_FAIL_IDX_EN
                            if ((bus.dut_out != exp_q[idx]) && !bus.fail_valid) begin
                                bus.fail_valid <= 1'b1;
                                bus.fail_idx   <= idx;
                            end
`endif
                            if (&idx) begin
                                bus.dut_in <= '0;
                                state      <= CHECK;
                            end else begin
                                bus.dut_in <= idx + 1'b1;
                            end
                        end
                    end
                    CHECK: begin
                        bus.pass <= (bus.signature == exp_q);
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb/tb_tt_sweep_ctrl.sv - self-checking bench for tt_sweep_ctrl (both settle depths)
module tb_tt_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        start;
    logic        abort;
    logic [15:0] exp_tt;
    logic [15:0] gate_fn;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tt_sweep_ctrl_if #(.N_IN(4)) b0 ();
    tt_sweep_ctrl_if #(.N_IN(4)) b1 ();

    assign b0.start       = start & ~sel;
    assign b1.start       = start & sel;
    assign b0.abort       = abort & ~sel;
    assign b1.abort       = abort & sel;
    assign b0.expected_tt = exp_tt;
    assign b1.expected_tt = exp_tt;
    assign b0.dut_out     = gate_fn[b0.dut_in];
    assign b1.dut_out     = gate_fn[b1.dut_in];

    tt_sweep_ctrl #(.N_IN(4), .SETTLE_CYCLES(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    tt_sweep_ctrl #(.N_IN(4), .SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    logic [3:0]  m_dut_in;
    logic        m_busy, m_done, m_pass;
    logic [15:0] m_sig;
    assign m_dut_in = sel ? b1.dut_in    : b0.dut_in;
    assign m_busy   = sel ? b1.busy      : b0.busy;
    assign m_done   = sel ? b1.done      : b0.done;
    assign m_pass   = sel ? b1.pass      : b0.pass;
    assign m_sig    = sel ? b1.signature : b0.signature;
`ifdef TT_SWEEP_FAIL_IDX_EN
    logic       m_fv;
    logic [3:0] m_fidx;
    assign m_fv   = sel ? b1.fail_valid : b0.fail_valid;
    assign m_fidx = sel ? b1.fail_idx   : b0.fail_idx;
`endif

    typedef struct {
        logic [15:0] g;
        logic [15:0] e;
        logic        p;
        logic [3:0]  fidx;
        logic        fv;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lowest input vector where the gate and the expected function disagree
    function automatic logic [4:0] first_diff(input logic [15:0] a, input logic [15:0] b);
        logic [4:0] r = 5'd0;
        for (int i = 15; i >= 0; i--)
            if (a[i] != b[i]) r = {1'b1, 4'(i)};
        return r;
    endfunction

    task automatic run_sweep(input bit s, input logic [15:0] g, input logic [15:0] e,
                             input logic xp, input logic [3:0] xfidx, input logic xfv,
                             input bit poke, input bit chained);
        int per;
        int total;
        int bad;
        logic [3:0] want;
        per   = s ? 2 : 3;
        total = 16 * per + 1;
        bad   = 0;
        sel     = s;
        gate_fn = g;
        if (!chained) begin
            exp_tt = e;
            start  = 1'b1;
            tick();
            start  = 1'b0;
        end
        for (int k = 0; k < total; k++) begin
            want = (k < 16 * per) ? 4'(k / per) : 4'd0;
            if (m_dut_in !== want || m_busy !== 1'b1 || m_done !== 1'b0) begin
                if (bad == 0)
                    $display("walk deviation at cycle %0d: dut_in=%0h busy=%b done=%b", k, m_dut_in, m_busy, m_done);
                bad++;
            end
            if (poke && k == 9)  start = 1'b1;
            if (poke && k == 10) start = 1'b0;
            tick();
        end
        chk("walk_errors", bad, 0);
        chk("done_pulse", m_done, 1'b1);
        chk("busy_end", m_busy, 1'b0);
        chk("pass", m_pass, xp);
        chk("signature", m_sig, g);
        chk("dut_in_end", m_dut_in, 4'd0);
`ifdef TT_SWEEP_FAIL_IDX_EN
        chk("fail_valid", m_fv, xfv);
        if (xfv) chk("fail_idx", m_fidx, xfidx);
`endif
    endtask

    initial begin
        logic [15:0] g;
        logic [15:0] e;
        logic [4:0]  fd;
        int          seen;
        bit          s;

        tbl[0] = '{16'hE677, 16'hE677, 1'b1, 4'd0,  1'b0};
        tbl[1] = '{16'hE677, 16'hE676, 1'b0, 4'd0,  1'b1};
        tbl[2] = '{16'h0000, 16'h0000, 1'b1, 4'd0,  1'b0};
        tbl[3] = '{16'hFFFF, 16'h7FFF, 1'b0, 4'd15, 1'b1};
        tbl[4] = '{16'hA5A5, 16'hA5B5, 1'b0, 4'd4,  1'b1};

        rst_n = 1'b0; sel = 1'b0; start = 1'b0; abort = 1'b0; exp_tt = '0; gate_fn = '0;

        // Reset with random input activity
        for (int i = 0; i < 4; i++) begin
            start   = 1'($urandom);
            abort   = 1'($urandom);
            exp_tt  = 16'($urandom);
            gate_fn = 16'($urandom);
            tick();
            chk("rst_outs0", {b0.dut_in, b0.busy, b0.done, b0.pass, b0.signature}, 0);
            chk("rst_outs1", {b1.dut_in, b1.busy, b1.done, b1.pass, b1.signature}, 0);
`ifdef TT_SWEEP_FAIL_IDX_EN
            chk("rst_fail", {b0.fail_valid, b0.fail_idx, b1.fail_valid, b1.fail_idx}, 0);
`endif
        end
        start = 1'b0; abort = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_outs0", {b0.dut_in, b0.busy, b0.done, b0.pass, b0.signature}, 0);
            chk("idle_outs1", {b1.dut_in, b1.busy, b1.done, b1.pass, b1.signature}, 0);
        end

        // Table-driven sweeps on the default settle depth
        for (int i = 0; i < 5; i++) begin
            run_sweep(1'b0, tbl[i].g, tbl[i].e, tbl[i].p, tbl[i].fidx, tbl[i].fv, 1'b0, 1'b0);
            tick();
            chk("done_one_cycle", m_done, 1'b0);
            chk("pass_held", m_pass, tbl[i].p);
        end

        // abort and start together in IDLE: abort wins
        sel = 1'b0; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_beats_start", m_busy, 1'b0);

        // Abort mid-sweep at E+20
        gate_fn = 16'hE677; exp_tt = 16'hE676; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
`ifdef TT_SWEEP_FAIL_IDX_EN
        chk("fail_before_abort", {m_fv, m_fidx}, 5'h10);
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", m_busy, 1'b0);
        chk("abort_dut_in", m_dut_in, 4'd0);
        chk("abort_no_done", m_done, 1'b0);
        chk("abort_partial_sig", m_sig, 16'h0037);
`ifdef TT_SWEEP_FAIL_IDX_EN
        chk("abort_fail_clr", m_fv, 1'b0);
`endif
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (m_done !== 1'b0 || m_busy !== 1'b0) seen++;
        end
        chk("quiet_after_abort", seen, 0);
        run_sweep(1'b0, 16'hE677, 16'hE677, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();

        // start while busy is ignored; start in the done cycle chains a new sweep
        run_sweep(1'b0, 16'hE677, 16'hE677, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        exp_tt = 16'hE676;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("chain_busy", m_busy, 1'b1);
        chk("chain_pass_clr", m_pass, 1'b0);
        run_sweep(1'b0, 16'hE677, 16'hE676, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        tick();

        // Single settle cycle instance
        run_sweep(1'b1, 16'hE677, 16'hE677, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("s1_done_low", m_done, 1'b0);

        // Asynchronous reset mid-sweep
        sel = 1'b0; gate_fn = 16'hE677; exp_tt = 16'hE677; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (29) tick();
        chk("pre_reset_sig", m_sig, 16'h0077);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {m_dut_in, m_busy, m_sig}, 0);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (m_done !== 1'b0 || m_busy !== 1'b0) seen++;
        end
        chk("quiet_after_reset", seen, 0);

        // Randomized sweeps against the truth-table model
        for (int r = 0; r < 8; r++) begin
            g = 16'($urandom);
            if ($urandom_range(1) == 1) e = g;
            else if ($urandom_range(1) == 1) e = g ^ (16'h1 << $urandom_range(15));
            else e = 16'($urandom);
            s  = 1'($urandom_range(1));
            fd = first_diff(g, e);
            run_sweep(s, g, e, (g == e), fd[3:0], fd[4], 1'b0, 1'b0);
            tick();
            chk("rand_done_low", m_done, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
